// File: rtl/axil_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : axil_sram_slave
// Description : AXI4-Lite slave backed by a byte-strobed 32-bit word SRAM,
//               with SLVERR on unmapped addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module axil_sram_slave #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    MEM_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    RD_WAIT    = 0
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [31:0]           WDATA,
    input  logic [3:0]            WSTRB,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic                  BVALID,
    output logic [1:0]            BRESP,
    input  logic                  BREADY,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [31:0]           RDATA,
    output logic [1:0]            RRESP,
    output logic                  RVALID,
    input  logic                  RREADY
);

    localparam int         C_IDX_W     = $clog2(MEM_WORDS);
    localparam logic [3:0] C_WAIT_INIT = (RD_WAIT > 0) ? 4'(RD_WAIT - 1) : 4'd0;
    localparam logic [1:0] C_OKAY      = 2'b00;
    localparam logic [1:0] C_SLVERR    = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

    logic [31:0]           r_mem [MEM_WORDS];

    logic                  r_aw_full;
    logic                  r_w_full;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wstrb;
    logic [ADDR_WIDTH-1:0] r_araddr;
    rd_state_t             r_rd_state;
    logic [3:0]            r_rd_cnt;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_commit;
    logic                  w_aw_full_next;
    logic                  w_w_full_next;
    logic [ADDR_WIDTH:0]   w_aw_diff;
    logic [ADDR_WIDTH:0]   w_ar_diff;
    logic                  w_aw_in_range;
    logic                  w_ar_in_range;
    logic [C_IDX_W-1:0]    w_aw_idx;
    logic [C_IDX_W-1:0]    w_ar_idx;
    rd_state_t             w_rd_state_next;
    logic [3:0]            w_cnt_next;
    logic                  w_r_load;
    logic                  w_r_done;
    logic                  w_unused;

    // Extra top bit catches addresses below BASE_ADDR as a borrow.
    assign w_aw_diff     = {1'b0, r_awaddr} - {1'b0, BASE_ADDR};
    assign w_ar_diff     = {1'b0, r_araddr} - {1'b0, BASE_ADDR};
    assign w_aw_in_range = (w_aw_diff[ADDR_WIDTH:C_IDX_W+2] == '0);
    assign w_ar_in_range = (w_ar_diff[ADDR_WIDTH:C_IDX_W+2] == '0);
    assign w_aw_idx      = w_aw_diff[C_IDX_W+1:2];
    assign w_ar_idx      = w_ar_diff[C_IDX_W+1:2];
    assign w_unused      = ^{w_aw_diff[1:0], w_ar_diff[1:0]};

    assign w_aw_hs        = AWVALID && AWREADY;
    assign w_w_hs         = WVALID && WREADY;
    assign w_ar_hs        = ARVALID && ARREADY;
    assign w_commit       = r_aw_full && r_w_full && !BVALID;
    assign w_aw_full_next = w_commit ? 1'b0 : (r_aw_full || w_aw_hs);
    assign w_w_full_next  = w_commit ? 1'b0 : (r_w_full || w_w_hs);

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            AWREADY   <= 1'b0;
            WREADY    <= 1'b0;
            BVALID    <= 1'b0;
            BRESP     <= C_OKAY;
        end else begin
            r_aw_full <= w_aw_full_next;
            r_w_full  <= w_w_full_next;
            AWREADY   <= !w_aw_full_next;
            WREADY    <= !w_w_full_next;
            if (w_commit) begin
                BVALID <= 1'b1;
                BRESP  <= w_aw_in_range ? C_OKAY : C_SLVERR;
            end else if (BREADY) begin
                BVALID <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_aw_hs) r_awaddr <= AWADDR;
        if (w_w_hs) begin
            r_wdata <= WDATA;
            r_wstrb <= WSTRB;
        end
        if (w_ar_hs) r_araddr <= ARADDR;
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge ACLK) begin
        if (ARESETn && w_commit && w_aw_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (r_wstrb[i]) r_mem[w_aw_idx][8*i +: 8] <= r_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_rd_state_next = r_rd_state;
        w_cnt_next      = r_rd_cnt;
        w_r_load        = 1'b0;
        w_r_done        = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                if (w_ar_hs) begin
                    w_cnt_next      = C_WAIT_INIT;
                    w_rd_state_next = (RD_WAIT == 0) ? R_RESP : R_WAIT;
                end
            end
            R_WAIT: begin
                if (r_rd_cnt == 4'd0) w_rd_state_next = R_RESP;
                else                  w_cnt_next      = r_rd_cnt - 4'd1;
            end
            R_RESP: begin
                // First edge in R_RESP samples the array; later edges wait on RREADY.
                if (!RVALID) begin
                    w_r_load = 1'b1;
                end else if (RREADY) begin
                    w_r_done        = 1'b1;
                    w_rd_state_next = R_IDLE;
                end
            end
            default: w_rd_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_rd_state <= R_IDLE;
            r_rd_cnt   <= 4'd0;
            ARREADY    <= 1'b0;
            RVALID     <= 1'b0;
            RDATA      <= 32'd0;
            RRESP      <= C_OKAY;
        end else begin
            r_rd_state <= w_rd_state_next;
            r_rd_cnt   <= w_cnt_next;
            ARREADY    <= (w_rd_state_next == R_IDLE);
            if (w_r_load) begin
                RVALID <= 1'b1;
                RDATA  <= w_ar_in_range ? r_mem[w_ar_idx] : 32'd0;
                RRESP  <= w_ar_in_range ? C_OKAY : C_SLVERR;
            end else if (w_r_done) begin
                RVALID <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
